shift_add_ctrl: RTL and testbench

- Sequencing FSM for the shift-add multiplier datapath: multiplicand register, accumulator/product register and adder.
- Accepts a start request and issues glitch-free load, add and shift commands, one step per clock.
- Iterates once per multiplier bit, then signals completion.
- Sits between the top-level user interface and the datapath registers. Its o_LOAD_cmd drives the multiplicand register's load clock-enable.

---
 rtl/shift_add_ctrl.sv | 85 ++++++++
 tb/tb_shift_add_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_ctrl.sv
// Sequencing FSM for a shift-add multiplier: issues registered load/add/shift commands.
// Defining SHIFT_ADD_CTRL_ABORT_EN adds a synchronous i_ABORT input.
module shift_add_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic                         i_CLK,
  input  logic                         i_RESET,
  input  logic                         i_START,
  input  logic                         i_LSB,
`ifdef SHIFT_ADD_CTRL_ABORT_EN
  input  logic                         i_ABORT,
`endif
  output logic                         o_LOAD_cmd,
  output logic                         o_ADD_cmd,
  output logic                         o_SHIFT_cmd,
  output logic                         o_BUSY,
  output logic                         o_DONE,
  output logic [$clog2(WIDTH+1)-1:0]   o_COUNT
);

  localparam int CW = $clog2(WIDTH+1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_TEST,
    S_ADD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic            abort;

`ifdef SHIFT_ADD_CTRL_ABORT_EN
  assign abort = i_ABORT;
`else
  assign abort = 1'b0;
`endif

  // In SHIFT the counter already holds the post-increment value.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (i_START) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_TEST;
      S_TEST:  state_nxt = i_LSB ? S_ADD : S_SHIFT;
      S_ADD:   state_nxt = S_SHIFT;
      S_SHIFT: state_nxt = (cnt == CNT_MAX) ? S_DONE : S_TEST;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort && (state != S_IDLE)) state_nxt = S_IDLE;
  end

  // Outputs decoded from next state so each command is a clean registered level.
  always_ff @(posedge i_CLK or negedge i_RESET) begin
    if (!i_RESET) begin
      state       <= S_IDLE;
      cnt         <= '0;
      o_LOAD_cmd  <= 1'b0;
      o_ADD_cmd   <= 1'b0;
      o_SHIFT_cmd <= 1'b0;
      o_BUSY      <= 1'b0;
      o_DONE      <= 1'b0;
    end else begin
      state       <= state_nxt;
      o_LOAD_cmd  <= (state_nxt == S_LOAD);
      o_ADD_cmd   <= (state_nxt == S_ADD);
      o_SHIFT_cmd <= (state_nxt == S_SHIFT);
      o_BUSY      <= (state_nxt != S_IDLE);
      o_DONE      <= (state_nxt == S_DONE);
      if (state_nxt == S_LOAD)
        cnt <= '0;
      else if ((state_nxt == S_SHIFT) && (cnt != CNT_MAX))
        cnt <= cnt + 1'b1;
    end
  end

  assign o_COUNT = cnt;

endmodule

// File: tb/tb_shift_add_ctrl.sv
// Self-checking bench for shift_add_ctrl with a behavioural product-register model.
module tb_shift_add_ctrl;

  localparam int W  = 4;
  localparam int CW = $clog2(W+1);

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          lsb;
  logic          abort;
  logic          load, add, shift, busy, done;
  logic [CW-1:0] count;

  shift_add_ctrl #(.WIDTH(W)) dut (
    .i_CLK       (clk),
    .i_RESET     (rst_n),
    .i_START     (start),
    .i_LSB       (lsb),
`ifdef SHIFT_ADD_CTRL_ABORT_EN
    .i_ABORT     (abort),
`endif
    .o_LOAD_cmd  (load),
    .o_ADD_cmd   (add),
    .o_SHIFT_cmd (shift),
    .o_BUSY      (busy),
    .o_DONE      (done),
    .o_COUNT     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Datapath model: product register with a carry bit on top, multiplicand register
  logic [2*W:0]  P;
  logic [W-1:0]  M;
  logic [W-1:0]  mcand_in;
  logic [W-1:0]  mult_in;
  byte           expq[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           prod;
    int           cyc;
    int           adds;
  } vec_t;
  vec_t tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_code(input string name, input byte act, input byte exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got step %c expected %c", name, act, exp);
    end
  endtask

  function automatic byte cur_code();
    if (int'(load) + int'(add) + int'(shift) + int'(done) > 1) return "X";
    if (load)  return "L";
    if (add)   return "A";
    if (shift) return "S";
    if (done)  return "D";
    if (busy)  return "T";
    return "I";
  endfunction

  // Advance one clock; the datapath reacts to the commands visible in the current cycle.
  task automatic step();
    logic [2*W:0] np;
    logic [W-1:0] nm;
    np = P;
    nm = M;
    if (load) begin
      np = {{(W+1){1'b0}}, mult_in};
      nm = mcand_in;
    end else if (add) begin
      np[2*W:W] = {1'b0, P[2*W-1:W]} + {1'b0, M};
    end else if (shift) begin
      np = P >> 1;
    end
    @(posedge clk);
    #1;
    P   = np;
    M   = nm;
    lsb = P[0];
  endtask

  task automatic build_exp(input logic [W-1:0] b);
    expq.delete();
    expq.push_back("L");
    for (int i = 0; i < W; i++) begin
      expq.push_back("T");
      if (b[i]) expq.push_back("A");
      expq.push_back("S");
    end
    expq.push_back("D");
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit toggle,
                        input string tag, output int prod, output int cyc, output int adds);
    int  guard;
    byte c;
    build_exp(b);
    mcand_in = a;
    mult_in  = b;
    start    = 1'b1;
    step();
    start = toggle;
    cyc   = 0;
    adds  = 0;
    guard = 0;
    while (busy && guard < 100) begin
      c = cur_code();
      if (cyc < expq.size()) check_code({tag, "_seq"}, c, expq[cyc]);
      else                   check_code({tag, "_seq_overrun"}, c, "I");
      if (c == "A") adds++;
      cyc++;
      guard++;
      if (toggle) start = (c == "D") ? 1'b0 : ~start;
      step();
    end
    if (guard >= 100) check({tag, "_timeout"}, 1, 0);
    prod = int'(P[2*W-1:0]);
    check({tag, "_count_hold"}, count, W);
    step();
    check_code({tag, "_idle_after"}, cur_code(), "I");
  endtask

  initial begin
    int  prod, cyc, adds, nt;
    logic [W-1:0] ra, rb;

    tbl[0] = '{a: 4'd13, b: 4'b1011, prod: 143, cyc: 13, adds: 3};
    tbl[1] = '{a: 4'd5,  b: 4'b0000, prod: 0,   cyc: 10, adds: 0};
    tbl[2] = '{a: 4'd15, b: 4'b1111, prod: 225, cyc: 14, adds: 4};
    tbl[3] = '{a: 4'd9,  b: 4'b0001, prod: 9,   cyc: 11, adds: 1};
    tbl[4] = '{a: 4'd1,  b: 4'b1000, prod: 8,   cyc: 11, adds: 1};

    rst_n = 1'b0; start = 1'b0; lsb = 1'b0; abort = 1'b0;
    P = '0; M = '0; mcand_in = '0; mult_in = '0;

    // Reset held for three cycles, then idle with start low
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_code("reset_outputs", cur_code(), "I");
      check("reset_count", count, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_code("idle_outputs", cur_code(), "I");
      check("idle_count", count, 0);
    end

    // Table-driven operations
    for (int i = 0; i < 5; i++) begin
      run_op(tbl[i].a, tbl[i].b, 1'b0, $sformatf("vec%0d", i), prod, cyc, adds);
      check($sformatf("vec%0d_product", i), prod, tbl[i].prod);
      check($sformatf("vec%0d_cycles", i), cyc, tbl[i].cyc);
      check($sformatf("vec%0d_adds", i), adds, tbl[i].adds);
    end

    // Randomised operations, some with start toggling while busy
    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom_range(0, (1 << W) - 1));
      rb = W'($urandom_range(0, (1 << W) - 1));
      run_op(ra, rb, 1'($urandom_range(0, 1)), "rand", prod, cyc, adds);
      check("rand_product", prod, int'(ra) * int'(rb));
      check("rand_cycles", cyc, 2 + 2 * W + $countones(rb));
      check("rand_adds", adds, $countones(rb));
    end

    // Asynchronous reset in the middle of an ADD
    mcand_in = 4'd3;
    mult_in  = 4'b1111;
    start    = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 10 && !add; i++) step();
    check("reach_add", add, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_add_low", add, 0);
    check("async_busy_low", busy, 0);
    check("async_count_zero", count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    P   = '0;
    lsb = 1'b0;
    step();
    check_code("after_reset_idle", cur_code(), "I");
    check("after_reset_busy", busy, 0);

    // Start held high: back-to-back operations with one IDLE cycle between them
    mcand_in = 4'd7;
    mult_in  = 4'b0000;
    build_exp(4'b0000);
    expq.push_back("I");
    build_exp_append: begin
      for (int i = 0; i < 10; i++) expq.push_back(expq[i]);
    end
    start = 1'b1;
    step();
    for (int i = 0; i < 21; i++) begin
      check_code("b2b_seq", cur_code(), expq[i]);
      if (i == 20) start = 1'b0;
      step();
    end
    check_code("b2b_end_idle", cur_code(), "I");
    step();
    check_code("b2b_no_restart", cur_code(), "I");

`ifdef SHIFT_ADD_CTRL_ABORT_EN
    // Abort during the second TEST
    mcand_in = 4'd6;
    mult_in  = 4'b0000;
    start    = 1'b1;
    step();
    start = 1'b0;
    nt = 0;
    for (int i = 0; i < 20 && nt < 2; i++) begin
      if (cur_code() == "T") nt++;
      if (nt < 2) step();
    end
    check("abort_reach_test2", nt, 2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_code("abort_idle", cur_code(), "I");
    check("abort_count", count, 1);
    check("abort_no_done", done, 0);
    step();
    check_code("abort_stays_idle", cur_code(), "I");
    check("abort_count_kept", count, 1);
`else
    nt = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
